// File: rtl/hier_step_sequencer.sv
// Multi-channel step sequencer: walks cnt over SIZE steps and sets one
// sticky flag per (channel, lane) at a per-channel rotated step.
module hier_step_sequencer #(
    parameter int SIZE     = 8,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0,
    parameter int SWEEP_W  = 8,
    localparam int CW      = $clog2(SIZE + 1),
    localparam int N       = CHANNELS * SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    output logic [CW-1:0]      cnt,
    output logic [N-1:0]       vld_for,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweeps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       vld_q, vld_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [N-1:0]       hit;
    state_t             fin_state;
    logic               wrap_en;

    if (SIZE < 1 || CHANNELS < 1 || (MODE != 0 && MODE != 1)) begin : g_param_err
        $error("hier_step_sequencer: illegal SIZE/CHANNELS/MODE");
    end

    if (MODE == 0) begin : g_oneshot
        assign fin_state = S_DONE;
        assign wrap_en   = 1'b0;
    end else begin : g_rolling
        assign fin_state = S_RUN;
        assign wrap_en   = 1'b1;
    end

    // Lanes whose rotated step equals the current count
    always_comb begin
        hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < SIZE; i++) begin
                if (((i + c) % SIZE) == int'(cnt_q)) begin
                    hit[c*SIZE+i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        sweeps_d = sweeps_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                vld_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    if (cnt_q != CW'(SIZE)) begin
                        vld_d = vld_q | hit;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(SIZE - 1)) begin
                            sweeps_d = sweeps_q + SWEEP_W'(1);
                            state_d  = fin_state;
                        end
                    end else if (wrap_en) begin
                        cnt_d = '0;
                        vld_d = '0;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    vld_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                vld_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vld_q    <= '0;
            sweeps_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            sweeps_q <= sweeps_d;
        end
    end

    assign cnt     = cnt_q;
    assign vld_for = vld_q;
    assign sweeps  = sweeps_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q != S_IDLE) && (cnt_q == CW'(SIZE));

endmodule
